// File: rtl/clip_plane_sequencer.sv
// Single-plane Sutherland-Hodgman clip sequencer for one triangle.
// Classifies vertices, drives the intersection unit, streams the clipped polygon.
module clip_plane_sequencer #(
    parameter int VERTEX_WIDTH = 16,
    parameter int FRAC_BITS    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [VERTEX_WIDTH-1:0] v0_x_i,
    input  logic [VERTEX_WIDTH-1:0] v0_y_i,
    input  logic [VERTEX_WIDTH-1:0] v0_z_i,
    input  logic [VERTEX_WIDTH-1:0] v0_w_i,
    input  logic [VERTEX_WIDTH-1:0] v1_x_i,
    input  logic [VERTEX_WIDTH-1:0] v1_y_i,
    input  logic [VERTEX_WIDTH-1:0] v1_z_i,
    input  logic [VERTEX_WIDTH-1:0] v1_w_i,
    input  logic [VERTEX_WIDTH-1:0] v2_x_i,
    input  logic [VERTEX_WIDTH-1:0] v2_y_i,
    input  logic [VERTEX_WIDTH-1:0] v2_z_i,
    input  logic [VERTEX_WIDTH-1:0] v2_w_i,
    input  logic [VERTEX_WIDTH-1:0] plane_a_i,
    input  logic [VERTEX_WIDTH-1:0] plane_b_i,
    input  logic [VERTEX_WIDTH-1:0] plane_c_i,
    input  logic [VERTEX_WIDTH-1:0] plane_d_i,
    output logic                    isect_start_o,
    output logic [VERTEX_WIDTH-1:0] isect_v1_x_o,
    output logic [VERTEX_WIDTH-1:0] isect_v1_y_o,
    output logic [VERTEX_WIDTH-1:0] isect_v1_z_o,
    output logic [VERTEX_WIDTH-1:0] isect_v1_w_o,
    output logic [VERTEX_WIDTH-1:0] isect_v2_x_o,
    output logic [VERTEX_WIDTH-1:0] isect_v2_y_o,
    output logic [VERTEX_WIDTH-1:0] isect_v2_z_o,
    output logic [VERTEX_WIDTH-1:0] isect_v2_w_o,
    output logic [VERTEX_WIDTH-1:0] isect_plane_a_o,
    output logic [VERTEX_WIDTH-1:0] isect_plane_b_o,
    output logic [VERTEX_WIDTH-1:0] isect_plane_c_o,
    output logic [VERTEX_WIDTH-1:0] isect_plane_d_o,
    input  logic                    isect_done_i,
    input  logic [VERTEX_WIDTH-1:0] isect_x_i,
    input  logic [VERTEX_WIDTH-1:0] isect_y_i,
    input  logic [VERTEX_WIDTH-1:0] isect_z_i,
    input  logic [VERTEX_WIDTH-1:0] isect_w_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [VERTEX_WIDTH-1:0] out_x_o,
    output logic [VERTEX_WIDTH-1:0] out_y_o,
    output logic [VERTEX_WIDTH-1:0] out_z_o,
    output logic [VERTEX_WIDTH-1:0] out_w_o,
    output logic                    out_last_o,
    output logic [2:0]              out_count_o,
    output logic                    culled_o
);

    localparam int W  = VERTEX_WIDTH;
    // 12.4 x 12.4 products are 24.8; four-term sum needs two guard bits
    localparam int DW = 2 * (W - FRAC_BITS) + 2 * FRAC_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_EDGE,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    // component order inside a vertex word: [0]=x [1]=y [2]=z [3]=w
    typedef logic [3:0][W-1:0] vtx_t;

    state_t          state;
    vtx_t [2:0]      vtx;
    vtx_t [3:0]      vbuf;
    vtx_t            plane_q;
    vtx_t            v1_q;
    vtx_t            v2_q;
    logic [2:0]      inside_q;
    logic [2:0]      cnt;
    logic [1:0]      idx;
    logic [1:0]      ed_q;
    logic            pend_q;

    vtx_t [2:0]      in_vtx;
    vtx_t            in_plane;
    vtx_t            isect_v;
    logic [2:0]      inside_c;
    logic [1:0]      e_nxt;
    logic [1:0]      cnt_p1;
    logic            s_in;
    logic            e_in;
    logic            emit_last;

    function automatic logic signed [DW-1:0] dist_f(input vtx_t v, input vtx_t p);
        logic signed [DW-1:0]  acc;
        logic signed [2*W-1:0] prod;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            prod = $signed(p[i]) * $signed(v[i]);
            acc  = acc + DW'(prod);
        end
        return acc;
    endfunction

    always_comb begin
        in_vtx[0] = {v0_w_i, v0_z_i, v0_y_i, v0_x_i};
        in_vtx[1] = {v1_w_i, v1_z_i, v1_y_i, v1_x_i};
        in_vtx[2] = {v2_w_i, v2_z_i, v2_y_i, v2_x_i};
        in_plane  = {plane_d_i, plane_c_i, plane_b_i, plane_a_i};
        isect_v   = {isect_w_i, isect_z_i, isect_y_i, isect_x_i};
    end

    logic signed [DW-1:0] dist0, dist1, dist2;

    always_comb begin
        dist0     = dist_f(vtx[0], plane_q);
        dist1     = dist_f(vtx[1], plane_q);
        dist2     = dist_f(vtx[2], plane_q);
        inside_c  = {~dist2[DW-1], ~dist1[DW-1], ~dist0[DW-1]};
        e_nxt     = (ed_q == 2'd2) ? 2'd0 : ed_q + 2'd1;
        s_in      = inside_q[ed_q];
        e_in      = inside_q[e_nxt];
        cnt_p1    = cnt[1:0] + 2'd1;
        emit_last = ({1'b0, idx} == (cnt - 3'd1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            vtx      <= '0;
            vbuf     <= '0;
            plane_q  <= '0;
            v1_q     <= '0;
            v2_q     <= '0;
            inside_q <= '0;
            cnt      <= '0;
            idx      <= '0;
            ed_q     <= '0;
            pend_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        vtx     <= in_vtx;
                        plane_q <= in_plane;
                        cnt     <= '0;
                        idx     <= '0;
                        ed_q    <= '0;
                        state   <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    inside_q <= inside_c;
                    if (inside_c == 3'b111) begin
                        vbuf[0] <= vtx[0];
                        vbuf[1] <= vtx[1];
                        vbuf[2] <= vtx[2];
                        cnt     <= 3'd3;
                        state   <= S_EMIT;
                    end else if (inside_c == 3'b000) begin
                        state <= S_IDLE;
                    end else begin
                        ed_q  <= '0;
                        state <= S_EDGE;
                    end
                end
                S_EDGE: begin
                    if (s_in != e_in) begin
                        // v1 is always the inside end of the edge
                        v1_q   <= s_in ? vtx[ed_q] : vtx[e_nxt];
                        v2_q   <= s_in ? vtx[e_nxt] : vtx[ed_q];
                        pend_q <= e_in;
                        state  <= S_ISSUE;
                    end else begin
                        if (s_in) begin
                            vbuf[cnt[1:0]] <= vtx[e_nxt];
                            cnt            <= cnt + 3'd1;
                        end
                        if (ed_q == 2'd2) begin
                            idx   <= '0;
                            state <= S_EMIT;
                        end else begin
                            ed_q <= e_nxt;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (isect_done_i) begin
                        vbuf[cnt[1:0]] <= isect_v;
                        if (pend_q) begin
                            vbuf[cnt_p1] <= v1_q;
                        end
                        cnt <= cnt + (pend_q ? 3'd2 : 3'd1);
                        if (ed_q == 2'd2) begin
                            idx   <= '0;
                            state <= S_EMIT;
                        end else begin
                            ed_q  <= e_nxt;
                            state <= S_EDGE;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready_i) begin
                        if (emit_last) begin
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o    = (state == S_IDLE);
        isect_start_o = (state == S_ISSUE);
        out_valid_o   = (state == S_EMIT);
        culled_o      = (state == S_CLASSIFY) && (inside_c == 3'b000);
        out_last_o    = out_valid_o && emit_last;
        out_count_o   = out_valid_o ? cnt : 3'd0;
        out_x_o       = out_valid_o ? vbuf[idx][0] : '0;
        out_y_o       = out_valid_o ? vbuf[idx][1] : '0;
        out_z_o       = out_valid_o ? vbuf[idx][2] : '0;
        out_w_o       = out_valid_o ? vbuf[idx][3] : '0;
    end

    always_comb begin
        isect_v1_x_o    = v1_q[0];
        isect_v1_y_o    = v1_q[1];
        isect_v1_z_o    = v1_q[2];
        isect_v1_w_o    = v1_q[3];
        isect_v2_x_o    = v2_q[0];
        isect_v2_y_o    = v2_q[1];
        isect_v2_z_o    = v2_q[2];
        isect_v2_w_o    = v2_q[3];
        isect_plane_a_o = plane_q[0];
        isect_plane_b_o = plane_q[1];
        isect_plane_c_o = plane_q[2];
        isect_plane_d_o = plane_q[3];
    end

endmodule
